mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Two-requester round-robin arbiter in front of the single-port memory_unit.
//  Requester 0 is mem_traversal; requester 1 is the UI/debug loader.
//  Latches one request, issues exactly one execute pulse, then waits for completion.
//  Returns read data and the done pulse to the winner, with a watchdog timeout.
// PARAMETERS
//  ADDR_W   `memory_addr_width   address width, both sides
//  DATA_W   `memory_data_width   data width, both sides
//  TIMEOUT  255                  max WAIT cycles before abort; counter is 8 bits
// PORTS
//  clk        in   1       system clock, rising edge
//  rst        in   1       asynchronous reset, ACTIVE-LOW
//  rN_req     in   1       N=0,1: request; held high until rN_grant
//  rN_func    in   2       memory_unit func code; sampled at grant edge only
//  rN_addr    in   ADDR_W  request address; sampled at grant edge only
//  rN_wdata   in   DATA_W  write data; sampled at grant edge only
//  rN_grant   out  1       1-cycle pulse: request accepted
//  rN_done    out  1       1-cycle pulse: transaction finished
//  rN_rdata   out  DATA_W  mem_rdata captured at completion; held until next done
//  rN_raddr   out  ADDR_W  mem_raddr captured at completion; held until next done
//  mem_func   out  2       to memory_unit.func
//  mem_exec   out  1       to memory_unit.execute; 1-cycle pulse
//  mem_addr   out  ADDR_W  to memory_unit.addr_in
//  mem_wdata  out  DATA_W  to memory_unit.data_in
//  mem_ready  in   1       from memory_unit.is_ready; high = idle
//  mem_rdata  in   DATA_W  from memory_unit.data_out
//  mem_raddr  in   ADDR_W  from memory_unit.addr_out
//  busy       out  1       high when state != IDLE
//  owner      out  1       index of current or last granted requester
//  timeout    out  1       1-cycle pulse, concurrent with the aborted rN_done
// BEHAVIOUR
//  Reset (rst=0, async)
//   - All outputs 0; state=IDLE; last=1, so r0 wins the first tie.
//   - Reset mid-transaction abandons the transaction; no done pulse is produced.
//  IDLE
//   - Leave only when mem_ready=1 and (r0_req|r1_req).
//   - Winner: the sole requester, else !last on a tie.
//   - At the edge: latch func/addr/wdata into mem_*; rN_grant<=1; mem_exec<=1.
//   - Also at the edge: owner<=N; last<=N; wcnt<=0; seen_busy<=0; go WAIT.
//  WAIT
//   - rN_grant and mem_exec drop after exactly 1 cycle.
//   - mem_func/mem_addr/mem_wdata hold stable until return to IDLE.
//   - mem_ready=0 sampled: seen_busy<=1.
//   - Completion: seen_busy=1 and mem_ready=1 sampled.
//     At that edge: rOwner_rdata<=mem_rdata; rOwner_raddr<=mem_raddr; rOwner_done<=1; go IDLE.
//   - wcnt increments every WAIT cycle.
//   - wcnt==TIMEOUT with no completion: rOwner_done<=1; timeout<=1; rdata unchanged; go IDLE.
//  Latency and handshake
//   - req sampled high at edge k: grant and mem_exec high in cycle k+1.
//   - done is high the cycle after completion is sampled.
//   - New grant no earlier than the cycle after done (no back-to-back overlap).
//   - req dropped before grant = request withdrawn; no transaction.
//   - req held through done = re-arbitrated as a new request.
//   - The non-owner's req is ignored (held pending) while busy.
//  Fairness
//   - Both requesters continuously requesting: grants strictly alternate.
//   - Neither requester waits more than one transaction.
// TESTING
//  1. Reset release, only r0_req, write func, addr=5, wdata=0xAA
//     -> r0_grant and mem_exec 1 cycle each; mem_addr=5, mem_wdata=0xAA held.
//     -> r0_done 1 cycle after model ready returns; r1 outputs remain 0.
//  2. r0_req and r1_req both high from reset
//     -> grant order r0,r1,r0,r1; owner toggles; never two grants without a done between.
//  3. Read: model returns data 0x1234 / raddr 9 on ready rise
//     -> r1_rdata=0x1234 and r1_raddr=9 in the done cycle; values hold afterwards.
//  4. Model never reasserts ready, TIMEOUT=4
//     -> done and timeout pulse together after WAIT count reaches 4; busy=0 next cycle.
//  5. rst pulled low during WAIT
//     -> all outputs 0 immediately; no done pulse; next request served normally.
//  6. mem_ready=0 while r0_req=1
//     -> no grant until ready=1; grant exactly 1 cycle after ready is sampled high.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of the single-port memory unit.
// Serves one latched request at a time: one execute pulse, then a watchdog-bounded wait for completion.

module mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              r0_req_i,
    input  logic [1:0]        r0_func_i,
    input  logic [ADDR_W-1:0] r0_addr_i,
    input  logic [DATA_W-1:0] r0_wdata_i,
    output logic              r0_grant_o,
    output logic              r0_done_o,
    output logic [DATA_W-1:0] r0_rdata_o,
    output logic [ADDR_W-1:0] r0_raddr_o,
    input  logic              r1_req_i,
    input  logic [1:0]        r1_func_i,
    input  logic [ADDR_W-1:0] r1_addr_i,
    input  logic [DATA_W-1:0] r1_wdata_i,
    output logic              r1_grant_o,
    output logic              r1_done_o,
    output logic [DATA_W-1:0] r1_rdata_o,
    output logic [ADDR_W-1:0] r1_raddr_o,
    output logic [1:0]        mem_func_o,
    output logic              mem_exec_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic [ADDR_W-1:0] mem_raddr_i,
    output logic              busy_o,
    output logic              owner_o,
    output logic              timeout_o
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    state_t                 state_q;
    logic                   last_q;
    logic                   owner_q;
    logic                   seen_busy_q;
    logic                   exec_q;
    logic                   timeout_q;
    logic [7:0]             wcnt_q;
    logic [1:0]             grant_q;
    logic [1:0]             done_q;
    logic [1:0]             func_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [DATA_W-1:0]      wdata_q;
    logic [1:0][DATA_W-1:0] rdata_q;
    logic [1:0][ADDR_W-1:0] raddr_q;

    logic [1:0] req;
    logic       winner;
    logic [1:0] winner_onehot;
    logic [1:0] owner_onehot;

    // On a tie the requester that was not served last wins, so grants alternate.
    always_comb begin
        req           = {r1_req_i, r0_req_i};
        winner        = (&req) ? ~last_q : req[1];
        winner_onehot = winner ? 2'b10 : 2'b01;
        owner_onehot  = owner_q ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            seen_busy_q <= 1'b0;
            exec_q      <= 1'b0;
            timeout_q   <= 1'b0;
            wcnt_q      <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            func_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            raddr_q     <= '0;
        end else begin
            grant_q   <= '0;
            done_q    <= '0;
            exec_q    <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_ready_i && (|req)) begin
                        func_q      <= winner ? r1_func_i  : r0_func_i;
                        addr_q      <= winner ? r1_addr_i  : r0_addr_i;
                        wdata_q     <= winner ? r1_wdata_i : r0_wdata_i;
                        grant_q     <= winner_onehot;
                        exec_q      <= 1'b1;
                        owner_q     <= winner;
                        last_q      <= winner;
                        wcnt_q      <= '0;
                        seen_busy_q <= 1'b0;
                        state_q     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Ready only counts as completion after the memory has been seen busy.
                    if (seen_busy_q && mem_ready_i) begin
                        rdata_q[owner_q] <= mem_rdata_i;
                        raddr_q[owner_q] <= mem_raddr_i;
                        done_q           <= owner_onehot;
                        state_q          <= S_IDLE;
                    end else if (wcnt_q == TIMEOUT_C) begin
                        done_q    <= owner_onehot;
                        timeout_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                        if (!mem_ready_i) begin
                            seen_busy_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign r0_grant_o  = grant_q[0];
    assign r1_grant_o  = grant_q[1];
    assign r0_done_o   = done_q[0];
    assign r1_done_o   = done_q[1];
    assign r0_rdata_o  = rdata_q[0];
    assign r1_rdata_o  = rdata_q[1];
    assign r0_raddr_o  = raddr_q[0];
    assign r1_raddr_o  = raddr_q[1];
    assign mem_func_o  = func_q;
    assign mem_exec_o  = exec_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = (state_q != S_IDLE);
    assign owner_o     = owner_q;
    assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a behavioural memory plus a transaction-level arbiter model
// (grant to sole/not-last requester, done min(latency,TIMEOUT)+1 cycles after grant).

module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int TO = 4;

    logic          clk;
    logic          rst_n;
    logic [1:0]    req;
    logic [1:0]    func  [2];
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];

    logic          r0_grant, r0_done, r1_grant, r1_done;
    logic [DW-1:0] r0_rdata, r1_rdata;
    logic [AW-1:0] r0_raddr, r1_raddr;
    logic [1:0]    mem_func;
    logic          mem_exec;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          memReady;
    logic [DW-1:0] memRdata;
    logic [AW-1:0] memRaddr;
    logic          busy, owner, timeout;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .r0_req_i(req[0]), .r0_func_i(func[0]), .r0_addr_i(addr[0]), .r0_wdata_i(wdata[0]),
        .r0_grant_o(r0_grant), .r0_done_o(r0_done), .r0_rdata_o(r0_rdata), .r0_raddr_o(r0_raddr),
        .r1_req_i(req[1]), .r1_func_i(func[1]), .r1_addr_i(addr[1]), .r1_wdata_i(wdata[1]),
        .r1_grant_o(r1_grant), .r1_done_o(r1_done), .r1_rdata_o(r1_rdata), .r1_raddr_o(r1_raddr),
        .mem_func_o(mem_func), .mem_exec_o(mem_exec), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_ready_i(memReady), .mem_rdata_i(memRdata), .mem_raddr_i(memRaddr),
        .busy_o(busy), .owner_o(owner), .timeout_o(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Behavioural memory: ready drops when execute is seen, returns after curLat cycles.
    logic [DW-1:0] memArr [16];
    logic          envBusy, envNever, memHoldLow, memNever;
    int            envCnt, curLat, fixedLat;
    logic [1:0]    envFunc;
    logic [AW-1:0] envAddr;
    logic [DW-1:0] envWdata;

    // Reference model state and the outputs it expects in the current cycle.
    logic [DW-1:0] refMem [16];
    logic          mBusy, mLast, pTimeout;
    int            doneAt;
    logic [DW-1:0] pData;
    logic [AW-1:0] pAddr;
    logic [1:0]    eGrant, eDone;
    logic          eTimeout, eExec, eBusy, eOwner;
    logic [DW-1:0] eRdata [2];
    logic [AW-1:0] eRaddr [2];
    logic [1:0]    eMemFunc;
    logic [AW-1:0] eMemAddr;
    logic [DW-1:0] eMemWdata;

    int   stimMode;
    logic txOpen, logSeq, sawTimeout;
    int   lastGrantCyc, lastDoneCyc;
    int   grantSeq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic newPayload(input int i);
        func[i]  = 2'($urandom_range(0, 3));
        addr[i]  = AW'($urandom_range(0, 15));
        wdata[i] = DW'($urandom);
    endtask

    // Predicts what the DUT shows in the next cycle from the inputs it is about to sample.
    task automatic modelStep();
        logic w;
        int   lat;
        eGrant   = '0;
        eDone    = '0;
        eTimeout = 1'b0;
        eExec    = 1'b0;
        if (!mBusy) begin
            if (memReady && (req[0] || req[1])) begin
                w = (req[0] && req[1]) ? ~mLast : req[1];
                eGrant[w] = 1'b1;
                eExec     = 1'b1;
                mBusy     = 1'b1;
                eOwner    = w;
                mLast     = w;
                eMemFunc  = func[w];
                eMemAddr  = addr[w];
                eMemWdata = wdata[w];
                if (memNever) lat = 1000;
                else if (fixedLat != 0) lat = fixedLat;
                else lat = int'($urandom_range(1, TO));
                curLat   = lat;
                pTimeout = (lat > TO);
                doneAt   = cyc + 1 + (pTimeout ? TO : lat) + 1;
                if (!pTimeout) begin
                    if (func[w] == 2'b01) refMem[addr[w][3:0]] = wdata[w];
                    pData = refMem[addr[w][3:0]];
                end
                pAddr = addr[w];
            end
        end else if (cyc + 1 == doneAt) begin
            eDone[eOwner] = 1'b1;
            mBusy = 1'b0;
            if (pTimeout) begin
                eTimeout = 1'b1;
            end else begin
                eRdata[eOwner] = pData;
                eRaddr[eOwner] = pAddr;
            end
        end
        eBusy = mBusy;
    endtask

    task automatic checkOutput();
        chk("r0_grant", 32'(r0_grant), 32'(eGrant[0]));
        chk("r1_grant", 32'(r1_grant), 32'(eGrant[1]));
        chk("r0_done", 32'(r0_done), 32'(eDone[0]));
        chk("r1_done", 32'(r1_done), 32'(eDone[1]));
        chk("timeout", 32'(timeout), 32'(eTimeout));
        chk("mem_exec", 32'(mem_exec), 32'(eExec));
        chk("busy", 32'(busy), 32'(eBusy));
        chk("owner", 32'(owner), 32'(eOwner));
        chk("r0_rdata", 32'(r0_rdata), 32'(eRdata[0]));
        chk("r0_raddr", 32'(r0_raddr), 32'(eRaddr[0]));
        chk("r1_rdata", 32'(r1_rdata), 32'(eRdata[1]));
        chk("r1_raddr", 32'(r1_raddr), 32'(eRaddr[1]));
        if (eBusy) begin
            chk("mem_func", 32'(mem_func), 32'(eMemFunc));
            chk("mem_addr", 32'(mem_addr), 32'(eMemAddr));
            chk("mem_wdata", 32'(mem_wdata), 32'(eMemWdata));
        end
        if (r0_grant || r1_grant) begin
            chk("no_overlap", 32'(txOpen), 32'd0);
            txOpen = 1'b1;
            lastGrantCyc = cyc;
            if (logSeq) grantSeq.push_back(r1_grant ? 1 : 0);
        end
        if (r0_done || r1_done) begin
            txOpen = 1'b0;
            lastDoneCyc = cyc;
            sawTimeout = timeout;
        end
    endtask

    task automatic envStep();
        if (envBusy) begin
            if (!envNever) begin
                envCnt--;
                if (envCnt == 0) begin
                    if (envFunc == 2'b01) memArr[envAddr[3:0]] = envWdata;
                    memRdata = memArr[envAddr[3:0]];
                    memRaddr = envAddr;
                    memReady = 1'b1;
                    envBusy  = 1'b0;
                end
            end
        end else if (memHoldLow) begin
            memReady = 1'b0;
        end else if (mem_exec) begin
            envFunc  = mem_func;
            envAddr  = mem_addr;
            envWdata = mem_wdata;
            memReady = 1'b0;
            envBusy  = 1'b1;
            envCnt   = curLat;
            envNever = memNever;
        end else begin
            memReady = 1'b1;
        end
    endtask

    task automatic applyStimulus();
        for (int i = 0; i < 2; i++) begin
            case (stimMode)
                0: if (eGrant[i]) req[i] = 1'b0;
                1: if (eGrant[i]) newPayload(i);
                default: begin
                    if (eGrant[i]) begin
                        if ($urandom_range(0, 1) == 1) newPayload(i);
                        else req[i] = 1'b0;
                    end else if (!req[i] && $urandom_range(0, 2) == 0) begin
                        req[i] = 1'b1;
                        newPayload(i);
                    end
                end
            endcase
        end
    endtask

    task automatic runCycles(input int n);
        repeat (n) begin
            modelStep();
            @(negedge clk);
            cyc++;
            checkOutput();
            envStep();
            applyStimulus();
        end
    endtask

    task automatic resetModel();
        mBusy = 1'b0; mLast = 1'b1; eOwner = 1'b0;
        eGrant = '0; eDone = '0; eTimeout = 1'b0; eExec = 1'b0; eBusy = 1'b0;
        eRdata[0] = '0; eRdata[1] = '0; eRaddr[0] = '0; eRaddr[1] = '0;
        eMemFunc = '0; eMemAddr = '0; eMemWdata = '0;
        txOpen = 1'b0; envBusy = 1'b0; memReady = 1'b1; memHoldLow = 1'b0; memNever = 1'b0;
        req = '0;
    endtask

    // Pulls reset mid-cycle, checks outputs clear at once, holds it two cycles.
    task automatic assertReset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_r0_grant", 32'(r0_grant), 32'd0);
        chk("rst_r0_done", 32'(r0_done), 32'd0);
        chk("rst_r0_rdata", 32'(r0_rdata), 32'd0);
        chk("rst_r0_raddr", 32'(r0_raddr), 32'd0);
        chk("rst_r1_grant", 32'(r1_grant), 32'd0);
        chk("rst_r1_done", 32'(r1_done), 32'd0);
        chk("rst_r1_rdata", 32'(r1_rdata), 32'd0);
        chk("rst_r1_raddr", 32'(r1_raddr), 32'd0);
        chk("rst_mem_func", 32'(mem_func), 32'd0);
        chk("rst_mem_exec", 32'(mem_exec), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        resetModel();
        runCycles(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        stimMode = 0; fixedLat = 0; curLat = 1; envCnt = 0; doneAt = 0;
        logSeq = 1'b0; sawTimeout = 1'b0; lastGrantCyc = 0; lastDoneCyc = 0;
        envNever = 1'b0; envFunc = '0; envAddr = '0; envWdata = '0;
        pTimeout = 1'b0; pData = '0; pAddr = '0;
        memRdata = '0; memRaddr = '0;
        for (int i = 0; i < 2; i++) begin
            func[i] = '0; addr[i] = '0; wdata[i] = '0;
        end
        for (int i = 0; i < 16; i++) begin
            memArr[i] = '0; refMem[i] = '0;
        end
        resetModel();
        $display("[TB] mem_arbiter bench, TIMEOUT=%0d", TO);

        assertReset();

        // Single write from r0
        fixedLat = 2; func[0] = 2'b01; addr[0] = 8'd5; wdata[0] = 16'h00AA; req[0] = 1'b1;
        runCycles(1);
        chk("t1_grant", 32'(r0_grant), 32'd1);
        chk("t1_exec", 32'(mem_exec), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'd5);
        chk("t1_wdata", 32'(mem_wdata), 32'hAA);
        runCycles(1);
        chk("t1_grant_drop", 32'(r0_grant), 32'd0);
        chk("t1_addr_hold", 32'(mem_addr), 32'd5);
        runCycles(2);
        chk("t1_done", 32'(r0_done), 32'd1);
        runCycles(3);

        // Both requesting continuously from reset
        assertReset();
        grantSeq.delete();
        logSeq = 1'b1; stimMode = 1; fixedLat = 0;
        newPayload(0); newPayload(1); req = 2'b11;
        runCycles(30);
        logSeq = 1'b0; stimMode = 0; req = '0;
        runCycles(8);
        chk("t2_grant_count", 32'(grantSeq.size() >= 4), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k < grantSeq.size()) chk("t2_order", 32'(grantSeq[k]), 32'(k % 2));
        end

        // Read returning 0x1234 from address 9
        memArr[9] = 16'h1234; refMem[9] = 16'h1234;
        fixedLat = 2; func[1] = 2'b00; addr[1] = 8'd9; req[1] = 1'b1;
        runCycles(4);
        chk("t3_done", 32'(r1_done), 32'd1);
        chk("t3_rdata", 32'(r1_rdata), 32'h1234);
        chk("t3_raddr", 32'(r1_raddr), 32'd9);
        runCycles(5);
        chk("t3_rdata_hold", 32'(r1_rdata), 32'h1234);

        // Memory never comes back: watchdog abort
        memNever = 1'b1; func[1] = 2'b00; addr[1] = 8'd7; req[1] = 1'b1;
        runCycles(8);
        chk("t4_latency", 32'(lastDoneCyc - lastGrantCyc), 32'(TO + 1));
        chk("t4_timeout", 32'(sawTimeout), 32'd1);
        chk("t4_rdata_kept", 32'(r1_rdata), 32'h1234);
        memNever = 1'b0; envBusy = 1'b0; memReady = 1'b1;
        runCycles(2);

        // Reset in the middle of a transaction, then a normal one
        fixedLat = 3; func[0] = 2'b00; addr[0] = 8'd4; req[0] = 1'b1;
        runCycles(2);
        assertReset();
        fixedLat = 2; func[0] = 2'b01; addr[0] = 8'd3; wdata[0] = 16'h5A5A; req[0] = 1'b1;
        runCycles(4);
        chk("t5_done", 32'(r0_done), 32'd1);
        chk("t5_rdata", 32'(r0_rdata), 32'h5A5A);
        runCycles(3);

        // Memory not ready: no grant; r1 withdraws before it is ever granted
        memHoldLow = 1'b1;
        runCycles(1);
        func[0] = 2'b01; addr[0] = 8'd2; wdata[0] = 16'h0F0F;
        func[1] = 2'b00; addr[1] = 8'd2; req = 2'b11;
        runCycles(3);
        chk("t6_nogrant", 32'(r0_grant | r1_grant), 32'd0);
        req[1] = 1'b0;
        runCycles(2);
        memHoldLow = 1'b0;
        runCycles(1);
        runCycles(1);
        chk("t6_grant_r0", 32'(r0_grant), 32'd1);
        chk("t6_grant_r1", 32'(r1_grant), 32'd0);
        runCycles(6);

        // Randomised traffic against the model
        stimMode = 2; fixedLat = 0;
        runCycles(400);
        stimMode = 0; req = '0;
        runCycles(10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
